// File: rtl/mdc_stream_sequencer_pkg.sv
// Shared types for the MDC stream sequencer: FSM states, counter and per-channel flag types.
package mdc_seq_package;

    localparam int unsigned DEF_N_IN   = 3;
    localparam int unsigned DEF_N_OUT  = 1;
    localparam int unsigned DEF_CNT_W  = 32;
    localparam int unsigned DEF_ITER_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WORK   = 2'd2,
        FINISH = 2'd3
    } seq_state_e;

    typedef logic [DEF_CNT_W-1:0]  cnt_t;
    typedef logic [DEF_ITER_W-1:0] iter_t;
    typedef logic [DEF_N_IN-1:0]   src_flags_t;
    typedef logic [DEF_N_OUT-1:0]  sink_flags_t;

endpackage

// File: rtl/mdc_stream_sequencer_if.sv
// Streamer/engine-side handshake bundle; master = sequencer, slave = streamers and engine monitor.
interface mdc_stream_sequencer_if
    import mdc_seq_package::*;
#(
    parameter int unsigned N_IN  = DEF_N_IN,
    parameter int unsigned N_OUT = DEF_N_OUT
) ();

    logic [N_IN-1:0]  src_req;
    logic [N_IN-1:0]  src_ready;
    logic [N_IN-1:0]  src_done;
    logic [N_OUT-1:0] sink_req;
    logic [N_OUT-1:0] sink_ready;
    logic [N_OUT-1:0] out_valid;
    logic [N_OUT-1:0] out_ready;

    modport master (
        output src_req, sink_req,
        input  src_ready, src_done, sink_ready, out_valid, out_ready
    );

    modport slave (
        input  src_req, sink_req,
        output src_ready, src_done, sink_ready, out_valid, out_ready
    );

endinterface

// File: rtl/mdc_stream_sequencer_beat_counter.sv
// Saturating per-sink beat counter with completion and overflow flags.
module mdc_beat_counter
    import mdc_seq_package::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             count_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             complete_o,
    output logic             overflow_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_adv;
    logic             at_limit;

    assign at_limit = (cnt_q == limit_i);
    assign cnt_adv  = (count_i && !at_limit) ? cnt_q + CNT_W'(1) : cnt_q;

    // Completion looks at the post-beat value so a final beat and the last
    // source done in the same cycle finish the iteration together.
    assign complete_o = (cnt_adv == limit_i);
    assign overflow_o = count_i && at_limit;

    always_comb begin
        cnt_d = clear_i ? '0 : cnt_adv;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mdc_stream_sequencer.sv
// Job sequencer: issues streamer requests, tracks per-channel completion over
// multiple iterations and raises one done pulse per job.
//
//  state  | meaning
//  IDLE   | waiting for start_i
//  ISSUE  | requests held until each channel accepts
//  WORK   | engine enabled, counting sink beats and source dones
//  FINISH | done_o pulse, back to IDLE next cycle
module mdc_stream_sequencer
    import mdc_seq_package::*;
#(
    parameter int unsigned N_IN   = DEF_N_IN,
    parameter int unsigned N_OUT  = DEF_N_OUT,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned ITER_W = DEF_ITER_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   start_i,
    input  logic [ITER_W-1:0]      nb_iter_i,
    input  logic [N_OUT*CNT_W-1:0] cnt_limit_i,
    mdc_stream_sequencer_if.master strm,
    output logic                   engine_clear_o,
    output logic                   engine_en_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [ITER_W-1:0]      iter_o
);

    localparam int unsigned IW1 = ITER_W + 1;

    seq_state_e               state_q, state_d;
    logic [N_IN-1:0]          src_req_q, src_req_d;
    logic [N_IN-1:0]          src_iss_q, src_iss_d;
    logic [N_IN-1:0]          src_done_q, src_done_d;
    logic [N_OUT-1:0]         sink_req_q, sink_req_d;
    logic [N_OUT-1:0]         sink_iss_q, sink_iss_d;
    logic [ITER_W-1:0]        nb_iter_q, nb_iter_d;
    logic [N_OUT*CNT_W-1:0]   limit_q, limit_d;
    logic [ITER_W-1:0]        iter_q, iter_d;
    logic                     eng_clr_q, eng_clr_d;
    logic                     eng_en_q, eng_en_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic                     busy_q, busy_d;

    logic [N_OUT-1:0]         beat;
    logic [N_OUT-1:0]         cnt_en;
    logic [N_OUT-1:0]         sink_cmp;
    logic [N_OUT-1:0]         sink_ovf;
    logic                     cnt_clr;
    logic                     launch;
    logic                     src_all_done;
    logic [IW1-1:0]           iter_max;
    logic [IW1-1:0]           iter_nxt;

    assign beat   = strm.out_valid & strm.out_ready;
    assign cnt_en = (state_q == WORK) ? beat : '0;

    for (genvar k = 0; k < N_OUT; k++) begin : g_sink
        mdc_beat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .clear_i    (cnt_clr),
            .count_i    (cnt_en[k]),
            .limit_i    (limit_q[k*CNT_W +: CNT_W]),
            .complete_o (sink_cmp[k]),
            .overflow_o (sink_ovf[k])
        );
    end

    always_comb begin
        state_d    = state_q;
        src_req_d  = src_req_q;
        src_iss_d  = src_iss_q;
        src_done_d = src_done_q;
        sink_req_d = sink_req_q;
        sink_iss_d = sink_iss_q;
        nb_iter_d  = nb_iter_q;
        limit_d    = limit_q;
        iter_d     = iter_q;
        eng_clr_d  = 1'b0;
        eng_en_d   = eng_en_q;
        done_d     = 1'b0;
        err_d      = err_q;
        busy_d     = busy_q;
        cnt_clr    = 1'b0;
        launch     = 1'b0;

        // A programmed count of 0 still runs one iteration.
        iter_max     = (nb_iter_q == '0) ? IW1'(1) : {1'b0, nb_iter_q};
        iter_nxt     = {1'b0, iter_q} + IW1'(1);
        src_all_done = &(src_done_q | strm.src_done);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = ISSUE;
                    nb_iter_d = nb_iter_i;
                    limit_d   = cnt_limit_i;
                    iter_d    = '0;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                    launch    = 1'b1;
                end
            end
            ISSUE: begin
                src_done_d = src_done_q | strm.src_done;
                src_iss_d  = src_iss_q | (src_req_q & strm.src_ready);
                sink_iss_d = sink_iss_q | (sink_req_q & strm.sink_ready);
                src_req_d  = src_req_q & ~strm.src_ready;
                sink_req_d = sink_req_q & ~strm.sink_ready;
                if ((&src_iss_d) && (&sink_iss_d)) begin
                    state_d  = WORK;
                    eng_en_d = 1'b1;
                end
            end
            WORK: begin
                src_done_d = src_done_q | strm.src_done;
                if (|sink_ovf) begin
                    err_d = 1'b1;
                end
                if (src_all_done && (&sink_cmp)) begin
                    eng_en_d = 1'b0;
                    if (iter_nxt < iter_max) begin
                        state_d = ISSUE;
                        iter_d  = iter_nxt[ITER_W-1:0];
                        launch  = 1'b1;
                    end else begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (launch) begin
            src_req_d  = '1;
            sink_req_d = '1;
            src_iss_d  = '0;
            sink_iss_d = '0;
            src_done_d = '0;
            eng_clr_d  = 1'b1;
            cnt_clr    = 1'b1;
        end

        if (clear_i) begin
            state_d    = IDLE;
            src_req_d  = '0;
            src_iss_d  = '0;
            src_done_d = '0;
            sink_req_d = '0;
            sink_iss_d = '0;
            nb_iter_d  = '0;
            limit_d    = '0;
            iter_d     = '0;
            eng_clr_d  = 1'b0;
            eng_en_d   = 1'b0;
            done_d     = 1'b0;
            err_d      = 1'b0;
            busy_d     = 1'b0;
            cnt_clr    = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            src_req_q  <= '0;
            src_iss_q  <= '0;
            src_done_q <= '0;
            sink_req_q <= '0;
            sink_iss_q <= '0;
            nb_iter_q  <= '0;
            limit_q    <= '0;
            iter_q     <= '0;
            eng_clr_q  <= 1'b0;
            eng_en_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_req_q  <= src_req_d;
            src_iss_q  <= src_iss_d;
            src_done_q <= src_done_d;
            sink_req_q <= sink_req_d;
            sink_iss_q <= sink_iss_d;
            nb_iter_q  <= nb_iter_d;
            limit_q    <= limit_d;
            iter_q     <= iter_d;
            eng_clr_q  <= eng_clr_d;
            eng_en_q   <= eng_en_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign strm.src_req   = src_req_q;
    assign strm.sink_req  = sink_req_q;
    assign engine_clear_o = eng_clr_q;
    assign engine_en_o    = eng_en_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign iter_o         = iter_q;

endmodule

// File: tb/tb_mdc_stream_sequencer.sv
// Self-checking bench for mdc_stream_sequencer: directed scenarios plus randomized jobs
// checked every cycle against an iteration-level reference model.
module tb_mdc_stream_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [15:0] nb_iter = '0;
    logic [31:0] cnt_limit = '0;
    logic        engine_clear, engine_en, busy, done, err;
    logic [15:0] iter_o;

    int total = 0;
    int bad = 0;
    int rdv[4];

    mdc_stream_sequencer_if #(.N_IN(3), .N_OUT(1)) strm ();

    mdc_stream_sequencer #(.N_IN(3), .N_OUT(1), .CNT_W(32), .ITER_W(16)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .clear_i        (clear),
        .start_i        (start),
        .nb_iter_i      (nb_iter),
        .cnt_limit_i    (cnt_limit),
        .strm           (strm),
        .engine_clear_o (engine_clear),
        .engine_en_o    (engine_en),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err),
        .iter_o         (iter_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        start = 1'b0;
        strm.src_ready = '0;
        strm.src_done = '0;
        strm.sink_ready = '0;
        strm.out_valid = '0;
        strm.out_ready = '0;
    endtask

    // Runs one job from a negedge with the DUT idle. rd[0..2] = source ready
    // cycle, rd[3] = sink ready cycle (relative to ISSUE entry); the model
    // decides each iteration's end from done flags and beat count alone.
    task automatic run_job(input int nb, input int limit, input int ovf, input int rd[4],
                           input bit done_issue, input int done_min, input bit stall);
        int  iters;
        bit  err_m;
        iters = (nb == 0) ? 1 : nb;
        err_m = 1'b0;
        nb_iter = 16'(nb);
        cnt_limit = 32'(limit);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int it = 0; it < iters; it++) begin
            int maxd;
            int cnt;
            int sent;
            bit [2:0] sd;
            bit ended;
            int done_at[3];
            maxd = 0;
            for (int i = 0; i < 4; i++) if (rd[i] > maxd) maxd = rd[i];
            cnt = 0;
            sent = 0;
            sd = '0;
            ended = 1'b0;
            for (int i = 0; i < 3; i++) done_at[i] = done_min + int'($urandom_range(0, limit + 2));
            for (int k = 0; k <= maxd; k++) begin
                chk("eng_clr_issue", engine_clear, (k == 0));
                if (k == 0) begin
                    chk("iter_issue", iter_o, it);
                    chk("busy_issue", busy, 1);
                    nb_iter = 16'($urandom);
                    cnt_limit = $urandom;
                end
                chk("src_req", strm.src_req, {rd[2] >= k, rd[1] >= k, rd[0] >= k});
                chk("sink_req", strm.sink_req, (rd[3] >= k));
                chk("en_issue", engine_en, 0);
                chk("err_issue", err, err_m);
                for (int i = 0; i < 3; i++) strm.src_ready[i] = (rd[i] == k);
                strm.sink_ready = (rd[3] == k);
                if (done_issue && k == maxd) begin
                    strm.src_done = '1;
                    sd = '1;
                end else begin
                    strm.src_done = '0;
                end
                @(negedge clk);
            end
            strm.src_ready = '0;
            strm.sink_ready = '0;
            strm.src_done = '0;
            for (int w = 0; w < 200 && !ended; w++) begin
                chk("en_work", engine_en, 1);
                chk("clr_work", engine_clear, 0);
                chk("req_work", {strm.src_req, strm.sink_req}, 0);
                chk("done_work", done, 0);
                chk("err_work", err, err_m);
                start = ($urandom_range(0, 3) == 0);
                if (sent < limit + ovf) begin
                    strm.out_valid = 1'b1;
                    strm.out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                end else begin
                    strm.out_valid = 1'b0;
                    strm.out_ready = 1'($urandom_range(0, 1));
                end
                if (strm.out_valid && strm.out_ready) begin
                    sent++;
                    if (cnt == limit) err_m = 1'b1;
                    else cnt++;
                end
                for (int i = 0; i < 3; i++) begin
                    if (!sd[i] && done_at[i] == w) begin
                        strm.src_done[i] = 1'b1;
                        sd[i] = 1'b1;
                    end else begin
                        strm.src_done[i] = 1'b0;
                    end
                end
                if (&sd && cnt == limit) ended = 1'b1;
                @(negedge clk);
            end
            idle_inputs();
        end
        chk("done_pulse", done, 1);
        chk("busy_finish", busy, 1);
        chk("en_finish", engine_en, 0);
        chk("err_finish", err, err_m);
        @(negedge clk);
        chk("done_after", done, 0);
        chk("busy_after", busy, 0);
        chk("iter_final", iter_o, iters - 1);
        chk("err_after", err, err_m);
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_outs", {engine_clear, engine_en, done, err, strm.src_req, strm.sink_req}, 0);
        chk("rst_iter", iter_o, 0);
        rst = 1'b0;
        @(negedge clk);

        // T1: single iteration, all ready at once
        rdv = '{0, 0, 0, 0};
        run_job(0, 4, 0, rdv, 1'b0, 0, 1'b0);

        // T2: three iterations
        run_job(3, 2, 0, rdv, 1'b0, 0, 1'b1);

        // T3: staggered readiness
        rdv = '{1, 3, 5, 2};
        run_job(1, 3, 0, rdv, 1'b0, 0, 1'b0);

        // T4: overflow beat lands before the late dones; err stays sticky
        rdv = '{0, 0, 0, 0};
        run_job(1, 2, 1, rdv, 1'b0, 8, 1'b0);
        // next start clears err (checked in the first ISSUE cycle)
        run_job(2, 1, 0, rdv, 1'b0, 0, 1'b0);

        // T6: limit 0 with dones on the ISSUE->WORK cycle
        rdv = '{0, 2, 1, 2};
        run_job(1, 0, 0, rdv, 1'b1, 0, 1'b0);

        // T5: clear during WORK of iteration 1 after an overflow
        nb_iter = 16'd2;
        cnt_limit = 32'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        strm.src_ready = '1;
        strm.sink_ready = '1;
        @(negedge clk);
        idle_inputs();
        strm.out_valid = 1'b1;
        strm.out_ready = 1'b1;
        strm.src_done = '1;
        @(negedge clk);
        idle_inputs();
        chk("t5_iter1", iter_o, 1);
        strm.src_ready = '1;
        strm.sink_ready = '1;
        @(negedge clk);
        idle_inputs();
        strm.out_valid = 1'b1;
        strm.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        idle_inputs();
        chk("t5_err_set", err, 1);
        chk("t5_busy", busy, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("t5_clr_busy", busy, 0);
        chk("t5_clr_outs", {engine_clear, engine_en, done, err, strm.src_req, strm.sink_req}, 0);
        chk("t5_clr_iter", iter_o, 0);
        @(negedge clk);
        chk("t5_idle", busy, 0);
        rdv = '{1, 0, 2, 1};
        run_job(1, 4, 0, rdv, 1'b0, 0, 1'b1);

        // randomized jobs
        for (int j = 0; j < 8; j++) begin
            int nb_r;
            int lim_r;
            int ovf_r;
            bit di_r;
            nb_r = int'($urandom_range(0, 3));
            lim_r = int'($urandom_range(0, 5));
            ovf_r = int'($urandom_range(0, 1));
            di_r = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 4; i++) rdv[i] = int'($urandom_range(0, 4));
            run_job(nb_r, lim_r, ovf_r, rdv, di_r, 0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
